// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_pkg                                                   |
// | Purpose  : Shared opcode encoding, default widths and the multiply  |
// |            FSM state type for the ALU execute stage.                 |
// | Contents : XLEN_DEF, REGW_DEF, alu_op_e, mul_state_e, op_is_legal()  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package alu_pkg;

   localparam int XLEN_DEF = 32;
   localparam int REGW_DEF = 5;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SLL  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SRA  = 4'd7,
      OP_SLT  = 4'd8,
      OP_SLTU = 4'd9,
      OP_MUL  = 4'd10
   } alu_op_e;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } mul_state_e;

   // Codes above MUL are reserved and retire as illegal.
   function automatic logic op_is_legal(input logic [3:0] op);
      return (op <= OP_MUL);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mul_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mul_iter                                                  |
// | Purpose  : Iterative shift-add multiplier, one partial product per  |
// |            cycle, XLEN iterations, low XLEN bits of the product.     |
// | Ports    : clk, rst_n       clock / async active-low reset           |
// |            start            load operands (honoured only when idle)  |
// |            mcand, mplier    operands                                 |
// |            busy             FSM is iterating                         |
// |            done             final iteration this cycle               |
// |            product          valid while done is high                 |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module mul_iter
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [XLEN-1:0] mcand,
   input  logic [XLEN-1:0] mplier,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] product
);

   localparam int CNT_W = $clog2(XLEN);

   mul_state_e       state_q, state_d;
   logic [XLEN-1:0]  acc_q, acc_d;
   logic [XLEN-1:0]  mcand_q, mcand_d;
   logic [XLEN-1:0]  mplier_q, mplier_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [XLEN-1:0]  acc_sum;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      count_d  = count_q;

      acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_MUL;
               acc_d    = '0;
               mcand_d  = mcand;
               mplier_d = mplier;
               count_d  = CNT_W'(XLEN - 1);
            end
         end
         ST_MUL: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q - CNT_W'(1);
            if (count_q == '0) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         count_q  <= count_d;
      end
   end

   assign busy    = (state_q == ST_MUL);
   // The last iteration's partial sum is the product; the caller registers it.
   assign done    = (state_q == ST_MUL) && (count_q == '0);
   assign product = acc_sum;

endmodule
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_exec_stage                                            |
// | Purpose  : Execute stage behind a synchronous-read register file.    |
// |            Latches the issued instruction, forwards its own last     |
// |            result, runs single-cycle ALU ops or an iterative MUL,    |
// |            and drives the register file write port from a register.  |
// | Ports    : clk, rst_n                 clock / async active-low reset |
// |            issue_valid/ready          issue handshake                |
// |            issue_op/rs1/rs2/rd/we     instruction fields             |
// |            rv1, rv2                   register file read data (T+1)  |
// |            wb_regWrite/wb_rd/wb_data  register file write port       |
// |            illegal_op                 pulse for undefined opcode     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int REGW = REGW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            issue_valid,
   output logic            issue_ready,
   input  logic [3:0]      issue_op,
   input  logic [REGW-1:0] issue_rs1,
   input  logic [REGW-1:0] issue_rs2,
   input  logic [REGW-1:0] issue_rd,
   input  logic            issue_we,
   input  logic [XLEN-1:0] rv1,
   input  logic [XLEN-1:0] rv2,
   output logic            wb_regWrite,
   output logic [REGW-1:0] wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            illegal_op
);

   localparam int SHW = $clog2(XLEN);

   // Stage s1: instruction whose operands arrive on rv1/rv2 this cycle.
   logic            s1_valid_q, s1_valid_d;
   logic [3:0]      s1_op_q,    s1_op_d;
   logic [REGW-1:0] s1_rs1_q,   s1_rs1_d;
   logic [REGW-1:0] s1_rs2_q,   s1_rs2_d;
   logic [REGW-1:0] s1_rd_q,    s1_rd_d;
   logic            s1_we_q,    s1_we_d;

   // Writeback register driving the register file write port.
   logic            wb_reg_write_q, wb_reg_write_d;
   logic [REGW-1:0] wb_rd_q,        wb_rd_d;
   logic [XLEN-1:0] wb_data_q,      wb_data_d;
   logic            illegal_q,      illegal_d;

   logic            s1_is_mul;
   logic            mul_start;
   logic            mul_busy;
   logic            mul_done;
   logic [XLEN-1:0] mul_product;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] alu_res;

   mul_iter #(
      .XLEN (XLEN)
   ) u_mul_iter (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .mcand   (op_a),
      .mplier  (op_b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   always_comb begin
      s1_is_mul   = s1_valid_q && (s1_op_q == OP_MUL);
      issue_ready = !mul_busy && !s1_is_mul;
      mul_start   = s1_is_mul && !mul_busy;

      // Distance-1 hazard: the instruction retiring now is not yet in the
      // register file read data, so take it from the writeback register.
      op_a = (wb_reg_write_q && (wb_rd_q == s1_rs1_q) && (s1_rs1_q != '0)) ? wb_data_q : rv1;
      op_b = (wb_reg_write_q && (wb_rd_q == s1_rs2_q) && (s1_rs2_q != '0)) ? wb_data_q : rv2;
      shamt = op_b[SHW-1:0];

      case (s1_op_q)
         OP_ADD:  alu_res = op_a + op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_SLL:  alu_res = op_a << shamt;
         OP_SRL:  alu_res = op_a >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_rs1_d   = s1_rs1_q;
      s1_rs2_d   = s1_rs2_q;
      s1_rd_d    = s1_rd_q;
      s1_we_d    = s1_we_q;

      if (issue_ready) begin
         s1_valid_d = issue_valid;
         if (issue_valid) begin
            s1_op_d  = issue_op;
            s1_rs1_d = issue_rs1;
            s1_rs2_d = issue_rs2;
            s1_rd_d  = issue_rd;
            s1_we_d  = issue_we;
         end
      end else if (mul_start) begin
         // The MUL moves into the multiplier; s1 keeps rd/we for its retire.
         s1_valid_d = 1'b0;
      end
   end

   always_comb begin
      wb_reg_write_d = 1'b0;
      wb_rd_d        = '0;
      wb_data_d      = '0;
      illegal_d      = 1'b0;

      if (mul_done) begin
         if (s1_we_q && (s1_rd_q != '0)) begin
            wb_reg_write_d = 1'b1;
            wb_rd_d        = s1_rd_q;
            wb_data_d      = mul_product;
         end
      end else if (s1_valid_q && !s1_is_mul) begin
         if (!op_is_legal(s1_op_q)) begin
            illegal_d = 1'b1;
         end else if (s1_we_q && (s1_rd_q != '0)) begin
            wb_reg_write_d = 1'b1;
            wb_rd_d        = s1_rd_q;
            wb_data_d      = alu_res;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q     <= 1'b0;
         s1_op_q        <= '0;
         s1_rs1_q       <= '0;
         s1_rs2_q       <= '0;
         s1_rd_q        <= '0;
         s1_we_q        <= 1'b0;
         wb_reg_write_q <= 1'b0;
         wb_rd_q        <= '0;
         wb_data_q      <= '0;
         illegal_q      <= 1'b0;
      end else begin
         s1_valid_q     <= s1_valid_d;
         s1_op_q        <= s1_op_d;
         s1_rs1_q       <= s1_rs1_d;
         s1_rs2_q       <= s1_rs2_d;
         s1_rd_q        <= s1_rd_d;
         s1_we_q        <= s1_we_d;
         wb_reg_write_q <= wb_reg_write_d;
         wb_rd_q        <= wb_rd_d;
         wb_data_q      <= wb_data_d;
         illegal_q      <= illegal_d;
      end
   end

   assign wb_regWrite = wb_reg_write_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign illegal_op  = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_alu_exec_stage                                         |
// | Purpose  : Self-checking bench for alu_exec_stage: directed cases    |
// |            plus a randomized program run against an architectural    |
// |            register-file model, with a modelled synchronous register |
// |            file (write-through) feeding rv1/rv2.                     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_alu_exec_stage;

   localparam logic [3:0] C_ADD = 4'd0, C_SUB = 4'd1, C_SRA = 4'd7, C_SLT = 4'd8,
                          C_SLTU = 4'd9, C_MUL = 4'd10;

   logic        clk;
   logic        rst_n;
   logic        issue_valid;
   logic        issue_ready;
   logic [3:0]  issue_op;
   logic [4:0]  issue_rs1, issue_rs2, issue_rd;
   logic        issue_we;
   logic [31:0] rv1, rv2;
   logic [31:0] drv_rv1, drv_rv2;
   logic [31:0] rf_rv1, rf_rv2;
   logic        wb_regWrite;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        illegal_op;

   logic        rf_mode;
   logic        rf_init;
   logic [31:0] rf [32];

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      bit          ill;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   alu_exec_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_op    (issue_op),
      .issue_rs1   (issue_rs1),
      .issue_rs2   (issue_rs2),
      .issue_rd    (issue_rd),
      .issue_we    (issue_we),
      .rv1         (rv1),
      .rv2         (rv2),
      .wb_regWrite (wb_regWrite),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .illegal_op  (illegal_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign rv1 = rf_mode ? rf_rv1 : drv_rv1;
   assign rv2 = rf_mode ? rf_rv2 : drv_rv2;

   // Register file environment: synchronous read, same-edge write-through.
   always @(posedge clk) begin
      if (rf_init) begin
         for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'd0 : $urandom;
      end else if (wb_regWrite && wb_rd != 5'd0) begin
         rf[wb_rd] <= wb_data;
      end
      rf_rv1 <= (issue_rs1 == 5'd0) ? 32'd0 :
                (wb_regWrite && wb_rd == issue_rs1) ? wb_data : rf[issue_rs1];
      rf_rv2 <= (issue_rs2 == 5'd0) ? 32'd0 :
                (wb_regWrite && wb_rd == issue_rs2) ? wb_data : rf[issue_rs2];
   end

   // Architectural meaning of each opcode, in plain arithmetic.
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int unsigned sh = b[4:0];
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a << sh;
         4'd6:    return a >> sh;
         4'd7:    return 32'(sa >>> sh);
         4'd8:    return (sa < sb) ? 32'd1 : 32'd0;
         4'd9:    return (a < b) ? 32'd1 : 32'd0;
         4'd10:   return a * b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issue one instruction at T, present operands at T+1, sample wb at T+2.
   task automatic do_op(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic we, input logic [31:0] a,
                        input logic [31:0] b, output logic wr, output logic [4:0] rdo,
                        output logic [31:0] data, output logic ill);
      issue_valid = 1'b1; issue_op = op; issue_rs1 = rs1; issue_rs2 = rs2;
      issue_rd = rd; issue_we = we;
      next_cycle();
      issue_valid = 1'b0; drv_rv1 = a; drv_rv2 = b;
      next_cycle();
      @(negedge clk);
      wr = wb_regWrite; rdo = wb_rd; data = wb_data; ill = illegal_op;
      next_cycle();
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #10;
      n_checks++;
      if ({wb_regWrite, wb_rd, wb_data, illegal_op} !== 39'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got wr=%b rd=%0d data=%h ill=%b, want all 0",
                  wb_regWrite, wb_rd, wb_data, illegal_op);
      end
      n_checks++;
      if (issue_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b, want 1", issue_ready);
      end
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (issue_ready !== 1'b1 || wb_regWrite !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: got ready=%b wr=%b, want ready=1 wr=0",
                  issue_ready, wb_regWrite);
      end
      next_cycle();
   endtask

   task automatic test_add();
      issue_valid = 1'b1; issue_op = C_ADD; issue_rs1 = 5'd1; issue_rs2 = 5'd2;
      issue_rd = 5'd3; issue_we = 1'b1;
      next_cycle();
      issue_valid = 1'b0; drv_rv1 = 32'd5; drv_rv2 = 32'd7;
      @(negedge clk);
      n_checks++;
      if (wb_regWrite !== 1'b0) begin
         n_fail++; $display("FAIL add_t1: wr=%b, want 0", wb_regWrite);
      end
      next_cycle();
      @(negedge clk);
      n_checks++;
      if (wb_regWrite !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'd12) begin
         n_fail++;
         $display("FAIL add_t2: wr=%b rd=%0d data=%0d, want 1/3/12", wb_regWrite, wb_rd, wb_data);
      end
      next_cycle();
      @(negedge clk);
      n_checks++;
      if (wb_regWrite !== 1'b0 || wb_data !== 32'd0) begin
         n_fail++; $display("FAIL add_t3: wr=%b data=%h, want 0/0", wb_regWrite, wb_data);
      end
      next_cycle();
   endtask

   task automatic test_forward();
      // x1 = x0 + x5 (x5 reads 10)
      issue_valid = 1'b1; issue_op = C_ADD; issue_rs1 = 5'd0; issue_rs2 = 5'd5;
      issue_rd = 5'd1; issue_we = 1'b1;
      next_cycle();
      drv_rv1 = 32'd0; drv_rv2 = 32'd10;
      // x2 = x1 + x1 issued right behind it
      issue_rs1 = 5'd1; issue_rs2 = 5'd1; issue_rd = 5'd2;
      next_cycle();
      issue_valid = 1'b0; drv_rv1 = 32'd0; drv_rv2 = 32'd0;   // stale register file data
      @(negedge clk);
      n_checks++;
      if (wb_regWrite !== 1'b1 || wb_rd !== 5'd1 || wb_data !== 32'd10) begin
         n_fail++;
         $display("FAIL fwd_first: wr=%b rd=%0d data=%0d, want 1/1/10", wb_regWrite, wb_rd, wb_data);
      end
      next_cycle();
      @(negedge clk);
      n_checks++;
      if (wb_regWrite !== 1'b1 || wb_rd !== 5'd2 || wb_data !== 32'd20) begin
         n_fail++;
         $display("FAIL fwd_second: wr=%b rd=%0d data=%0d, want 1/2/20", wb_regWrite, wb_rd, wb_data);
      end
      next_cycle();
   endtask

   task automatic test_mul();
      int bad_stall = 0;
      issue_valid = 1'b1; issue_op = C_MUL; issue_rs1 = 5'd1; issue_rs2 = 5'd2;
      issue_rd = 5'd4; issue_we = 1'b1;
      next_cycle();
      drv_rv1 = 32'hFFFF_FFFF; drv_rv2 = 32'd3;
      // A new request is held throughout the stall.
      issue_op = C_ADD; issue_rs1 = 5'd5; issue_rs2 = 5'd6; issue_rd = 5'd7;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk);
         if (issue_ready !== 1'b0 || wb_regWrite !== 1'b0) bad_stall++;
         next_cycle();
      end
      n_checks++;
      if (bad_stall != 0) begin
         n_fail++; $display("FAIL mul_stall: %0d cycles with ready/wr high in T+1..T+33, want 0", bad_stall);
      end
      @(negedge clk);   // T+34
      n_checks++;
      if (issue_ready !== 1'b1) begin
         n_fail++; $display("FAIL mul_ready_back: ready=%b at T+34, want 1", issue_ready);
      end
      n_checks++;
      if (wb_regWrite !== 1'b1 || wb_rd !== 5'd4 || wb_data !== 32'hFFFF_FFFD) begin
         n_fail++;
         $display("FAIL mul_wb: wr=%b rd=%0d data=%h, want 1/4/fffffffd", wb_regWrite, wb_rd, wb_data);
      end
      next_cycle();    // T+35: held ADD now in s1
      issue_valid = 1'b0; drv_rv1 = 32'd1; drv_rv2 = 32'd2;
      @(negedge clk);
      n_checks++;
      if (wb_regWrite !== 1'b0) begin
         n_fail++; $display("FAIL mul_wb_once: wr=%b at T+35, want 0", wb_regWrite);
      end
      next_cycle();
      @(negedge clk);
      n_checks++;
      if (wb_regWrite !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'd3) begin
         n_fail++;
         $display("FAIL held_issue: wr=%b rd=%0d data=%0d, want 1/7/3", wb_regWrite, wb_rd, wb_data);
      end
      next_cycle();
   endtask

   task automatic test_shift_cmp();
      logic wr, ill; logic [4:0] rdo; logic [31:0] d;
      do_op(C_SRA, 5'd1, 5'd2, 5'd9, 1'b1, 32'h8000_0000, 32'h21, wr, rdo, d, ill);
      n_checks++;
      if (wr !== 1'b1 || d !== 32'hC000_0000) begin
         n_fail++; $display("FAIL sra: wr=%b data=%h, want 1/c0000000", wr, d);
      end
      do_op(C_SLT, 5'd1, 5'd2, 5'd9, 1'b1, 32'hFFFF_FFFF, 32'd1, wr, rdo, d, ill);
      n_checks++;
      if (wr !== 1'b1 || d !== 32'd1) begin
         n_fail++; $display("FAIL slt: wr=%b data=%h, want 1/1", wr, d);
      end
      do_op(C_SLTU, 5'd1, 5'd2, 5'd9, 1'b1, 32'hFFFF_FFFF, 32'd1, wr, rdo, d, ill);
      n_checks++;
      if (wr !== 1'b1 || d !== 32'd0) begin
         n_fail++; $display("FAIL sltu: wr=%b data=%h, want 1/0", wr, d);
      end
      do_op(C_SUB, 5'd1, 5'd2, 5'd9, 1'b1, 32'd3, 32'd5, wr, rdo, d, ill);
      n_checks++;
      if (wr !== 1'b1 || d !== 32'hFFFF_FFFE) begin
         n_fail++; $display("FAIL sub_wrap: wr=%b data=%h, want 1/fffffffe", wr, d);
      end
   endtask

   task automatic test_rd0_illegal();
      logic wr, ill; logic [4:0] rdo; logic [31:0] d;
      do_op(C_ADD, 5'd1, 5'd2, 5'd0, 1'b1, 32'd4, 32'd4, wr, rdo, d, ill);
      n_checks++;
      if (wr !== 1'b0 || ill !== 1'b0) begin
         n_fail++; $display("FAIL rd0: wr=%b ill=%b, want 0/0", wr, ill);
      end
      do_op(4'd12, 5'd1, 5'd2, 5'd6, 1'b1, 32'd4, 32'd4, wr, rdo, d, ill);
      n_checks++;
      if (wr !== 1'b0 || ill !== 1'b1) begin
         n_fail++; $display("FAIL illegal: wr=%b ill=%b, want 0/1", wr, ill);
      end
      @(negedge clk);
      n_checks++;
      if (illegal_op !== 1'b0) begin
         n_fail++; $display("FAIL illegal_pulse: ill=%b next cycle, want 0", illegal_op);
      end
      next_cycle();
   endtask

   task automatic test_reset_mid_mul();
      int writes = 0;
      issue_valid = 1'b1; issue_op = C_MUL; issue_rs1 = 5'd1; issue_rs2 = 5'd2;
      issue_rd = 5'd8; issue_we = 1'b1;
      next_cycle();
      issue_valid = 1'b0; drv_rv1 = 32'd6; drv_rv2 = 32'd7;
      for (int k = 0; k < 9; k++) next_cycle();
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({wb_regWrite, wb_rd, wb_data, illegal_op} !== 39'd0 || issue_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midmul_reset: wr=%b rd=%0d data=%h ill=%b ready=%b, want 0/0/0/0/1",
                  wb_regWrite, wb_rd, wb_data, illegal_op, issue_ready);
      end
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (issue_ready !== 1'b1) begin
         n_fail++; $display("FAIL midmul_ready: ready=%b after release, want 1", issue_ready);
      end
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (wb_regWrite !== 1'b0) writes++;
         next_cycle();
      end
      n_checks++;
      if (writes != 0) begin
         n_fail++; $display("FAIL midmul_nowb: %0d writebacks after abort, want 0", writes);
      end
   endtask

   task automatic test_random();
      exp_t        q[$];
      exp_t        e;
      logic [31:0] ref_rf[32];
      bit          hold = 0;
      int          bad_rf = 0;
      rf_mode = 1'b1;
      rf_init = 1'b1;
      next_cycle();
      rf_init = 1'b0;
      for (int i = 0; i < 32; i++) ref_rf[i] = rf[i];
      for (int cyc = 0; cyc < 700; cyc++) begin
         if (cyc >= 600) begin
            issue_valid = 1'b0;
         end else if (!hold) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_op    = 4'($urandom_range(0, 15));
            if (issue_op == C_MUL && $urandom_range(0, 3) != 0) issue_op = C_ADD;
            issue_rs1   = 5'($urandom_range(0, 7));
            issue_rs2   = 5'($urandom_range(0, 7));
            issue_rd    = 5'($urandom_range(0, 7));
            issue_we    = ($urandom_range(0, 7) != 0);
         end
         @(negedge clk);
         if (wb_regWrite === 1'b1) begin
            n_checks++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL rand_wb: unexpected write rd=%0d data=%h, want none", wb_rd, wb_data);
            end else begin
               e = q.pop_front();
               if (e.ill || wb_rd !== e.rd || wb_data !== e.data) begin
                  n_fail++;
                  $display("FAIL rand_wb: got rd=%0d data=%h, want ill=%0d rd=%0d data=%h",
                           wb_rd, wb_data, e.ill, e.rd, e.data);
               end
            end
         end
         if (illegal_op === 1'b1) begin
            n_checks++;
            if (q.size() == 0) begin
               n_fail++; $display("FAIL rand_ill: unexpected illegal_op pulse, want none");
            end else begin
               e = q.pop_front();
               if (!e.ill) begin
                  n_fail++;
                  $display("FAIL rand_ill: got illegal pulse, want write rd=%0d data=%h", e.rd, e.data);
               end
            end
         end
         if (issue_valid && issue_ready) begin
            hold = 0;
            if (issue_op > C_MUL) begin
               e.ill = 1; e.rd = '0; e.data = '0;
               q.push_back(e);
            end else if (issue_we && issue_rd != 5'd0) begin
               e.ill  = 0;
               e.rd   = issue_rd;
               e.data = ref_alu(issue_op, ref_rf[issue_rs1], ref_rf[issue_rs2]);
               ref_rf[issue_rd] = e.data;
               q.push_back(e);
            end
         end else begin
            hold = issue_valid;
         end
         next_cycle();
      end
      n_checks++;
      if (q.size() != 0) begin
         n_fail++; $display("FAIL rand_drain: %0d expected writebacks never seen, want 0", q.size());
      end
      for (int i = 0; i < 32; i++) if (rf[i] !== ref_rf[i]) bad_rf++;
      n_checks++;
      if (bad_rf != 0) begin
         n_fail++; $display("FAIL rand_regfile: %0d registers differ from reference, want 0", bad_rf);
      end
      rf_mode = 1'b0;
   endtask

   initial begin
      issue_valid = 1'b0; issue_op = '0; issue_rs1 = '0; issue_rs2 = '0;
      issue_rd = '0; issue_we = 1'b0; drv_rv1 = '0; drv_rv2 = '0;
      rf_mode = 1'b0; rf_init = 1'b0;
      test_reset();
      test_add();
      test_forward();
      test_mul();
      test_shift_cmp();
      test_rd0_illegal();
      test_reset_mid_mul();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage directly downstream of the 32x32 register file (synchronous read, same-edge write-through bypass).
- Issues the source register addresses to the register file and consumes the registered operands one cycle later.
- Computes the ALU result; MUL takes 32 cycles through an iterative shift-add unit.
- Drives the register file write port (regWrite/rd/data) from a registered writeback stage, and forwards its own most recent result to close the distance-1 hazard.

Parameters:
XLEN, 32, datapath width (MUL iteration count = XLEN)
REGW, 5, register address width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  instruction presented this cycle
issue_ready  out  1  stage can accept; transfer = issue_valid & issue_ready
issue_op  in  4  opcode, from alu_pkg
issue_rs1  in  REGW  source 1 address; the same signal drives register file rs1
issue_rs2  in  REGW  source 2 address; the same signal drives register file rs2
issue_rd  in  REGW  destination address
issue_we  in  1  instruction writes rd
rv1  in  XLEN  register file read data 1, valid cycle after issue
rv2  in  XLEN  register file read data 2, valid cycle after issue
wb_regWrite  out  1  one-cycle write strobe to register file
wb_rd  out  REGW  write address
wb_data  out  XLEN  write data
illegal_op  out  1  one-cycle pulse, undefined opcode retired

Behaviour:
- Reset (async, rst_n=0): all outputs 0 except issue_ready; issue_ready=1 once out of reset. s1_valid=0, FSM=IDLE. An in-flight MUL is aborted with no writeback.
- Stage s1 (op/rs1/rs2/rd/we/valid) is captured on accepted issue at edge end of T and aligns with rv1/rv2 in cycle T+1.
- Operand forwarding in cycle T+1:
  - opA = wb_data if wb_regWrite && wb_rd==s1_rs1 && s1_rs1!=0; otherwise rv1. opB likewise from s1_rs2/rv2.
  - Register x0 always reads 0 through the register file; forwarding never targets x0.
- Ops:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, MUL=10. Codes 11-15 are illegal.
  - Shifts use opB[4:0]. SLT/SLTU return 0/1. MUL returns the low XLEN bits. All arithmetic wraps modulo 2^XLEN.
- Single-cycle ops: result registered at end of T+1. wb_regWrite = s1_we && s1_rd!=0, visible in cycle T+2 for exactly one cycle. Back-to-back issue every cycle is allowed.
- Illegal op: no write, illegal_op=1 in cycle T+2.
- FSM states IDLE and MUL:
  - IDLE->MUL at end of T+1 when s1 holds MUL: multiplicand/multiplier are loaded and count=XLEN-1.
  - In MUL, each cycle adds the shifted multiplicand when the multiplier LSB=1, shifts, and decrements count.
  - At count==0 the FSM registers the writeback and returns to IDLE.
  - MUL issued at T writes back in cycle T+34.
- issue_ready = (FSM==IDLE) && !(s1_valid && s1_op==MUL). For a MUL issued at T, issue_ready is low in T+1..T+33 and high again in T+34.
- While ready is low, issue_valid is ignored and s1 holds.
- Hazard coverage:
  - Distance 1 is covered by internal forwarding.
  - Distance 2, and the first issue after a MUL, are covered by register file write-through, because the read and the write share the same edge.
- Simultaneous events: reset wins over everything. wb outputs are cleared to 0 in any cycle without a retiring instruction.

Decomposition:
- alu_pkg holds the opcode constants/enum, XLEN/REGW defaults, and the FSM state type.
- Sub-module mul_iter handles the iterative shift-add multiply (start, operands, busy, done, product). It is instantiated once.
- The forwarding mux and single-cycle ALU stay in alu_exec_stage.

Test Plan:
- Reset mid-MUL: assert rst_n=0 at cycle 10 of a MUL -> all wb outputs 0, issue_ready=1 after release, no writeback ever.
- ADD, rv1=5, rv2=7, rd=3, issued at T -> wb_regWrite=1, wb_rd=3, wb_data=12 in cycle T+2 only.
- Back-to-back ADD x1=x0+imm-loaded(rv=10) then ADD x2=x1+x1 on the next cycle, with stale rv1=rv2=0 -> second wb_data=20 via forwarding.
- MUL, rv1=0xFFFF_FFFF, rv2=3 -> wb_data=0xFFFF_FFFD at T+34; issue_ready low T+1..T+33; a request held during stall is accepted at T+34.
- SRA, rv1=0x8000_0000, rv2=0x21 -> wb_data=0xC000_0000. SLT of -1 vs 1 -> 1; SLTU of -1 vs 1 -> 0.
- rd=0 with we=1 -> wb_regWrite=0. op=12 -> illegal_op pulse, no write.
